mul_div_sequencer: RTL
======================

Name: mul_div_sequencer

Overview:
Multi-cycle multiply/divide unit (MDU) with its own sequencing FSM. It owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU iteratively over WIDTH/BITS_PER_CYCLE cycles, plus single-cycle MTHI/MTLO. It sits beside ALU32Bit and is driven by the main instruction decoder. It raises Stall to freeze instruction fetch whenever a new MDU op or a HI/LO read arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per cycle; legal values 1, 2, 4. Busy cycles N = WIDTH/BITS_PER_CYCLE.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high.
Start  input  1  issue the op on Op this cycle.
Op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
OperandA  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
OperandB  input  WIDTH  rt value (multiplier/divisor).
ReadHiLo  input  1  decoder is executing MFHI/MFLO this cycle.
Busy  output  1  iterative op in progress.
Stall  output  1  combinational; hold the fetch unit PC and instruction.
Done  output  1  one-cycle pulse when the iterative result is committed.
DivByZero  output  1  one-cycle pulse coincident with Done for DIV/DIVU with OperandB==0.
Hi  output  WIDTH  HI register.
Lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state, including mid-op): state=IDLE; Hi=0, Lo=0; Busy, Done, DivByZero=0; counter=0. The partial result is discarded.
- States:
  - IDLE: no operation in flight.
  - RUN: iterating.
  - COMMIT: one cycle.
- IDLE:
  - Start with Op 1–4: latch operands and op, load counter=N, go to RUN.
  - Signed ops latch absolute values plus the result-sign flags.
  - Start with Op 5: Hi<=OperandA at that edge, stay IDLE.
  - Start with Op 6: Lo<=OperandA at that edge, stay IDLE.
  - Op 0/7: no effect.
- RUN:
  - Each edge retires BITS_PER_CYCLE bits and decrements the counter.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, partial remainder plus quotient.
  - When the counter reaches 0, go to COMMIT.
- COMMIT:
  - Apply sign correction.
  - At the exit edge: Hi<=upper/remainder, Lo<=lower/quotient; Done=1 and DivByZero (if applicable) during the COMMIT cycle; go to IDLE.
- Latency: Start accepted at edge E0. Busy=1 for cycles E0..E(N+1), i.e. through COMMIT. Hi/Lo update at edge E(N+1).
- Stall = Busy & (Start & Op!=0 & Op!=7 | ReadHiLo).
  - Start while Busy is ignored; the decoder re-presents it each cycle until Stall falls.
  - Stall is 0 in IDLE.
  - In the COMMIT cycle Stall is still 1; a re-presented op or read proceeds on the following cycle.
- Arithmetic:
  - MULT: signed 64-bit product. MULTU: unsigned 64-bit product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (no trap).
- Divide by zero (DIV or DIVU): full N cycles still elapse; Lo=all ones, Hi=OperandA (raw, no sign correction); DivByZero pulses.
- Hi/Lo hold their values while Busy. Reads during RUN return the old values, but the decoder is stalled.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> Busy for 33 cycles; Done pulses; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; repeat with BITS_PER_CYCLE=4 -> Busy for 9 cycles, same result.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=100, B=0 -> Done and DivByZero high the same cycle; Hi=0x64, Lo=0xFFFFFFFF.
- Start MULT, then ReadHiLo=1 and a second Start DIVU during RUN -> Stall=1 every cycle until IDLE; the second op is accepted the cycle after COMMIT; its result is correct; the first result is visible before it.
- MTHI 0x1234 then MTLO 0x5678 in IDLE -> Hi/Lo update on consecutive edges with no Busy. Then assert Reset mid-RUN of a MULT -> all outputs 0 immediately, no Done pulse, IDLE accepts a new Start next cycle.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both run on
// operand magnitudes and apply sign correction in a single COMMIT cycle.
// MTHI/MTLO are single-cycle writes that are accepted only while idle.
module mul_div_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               dbz_pend_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;   // product upper half or partial remainder
    logic [WIDTH-1:0]   wrk_q;   // multiplier bits out / quotient bits in
    logic [WIDTH-1:0]   opb_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               op_iter_s;
    logic               op_signed_s;
    logic               op_live_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   wrk_d;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_res_s;
    logic [WIDTH-1:0]   lo_res_s;

    // Decode the presented op and form operand magnitudes for signed ops.
    always_comb begin
        op_iter_s   = (Op >= OP_MULT) && (Op <= OP_DIVU);
        op_signed_s = (Op == OP_MULT) || (Op == OP_DIV);
        op_live_s   = (Op != OP_NONE) && (Op != OP_RSVD);
        a_neg_s     = op_signed_s & OperandA[WIDTH-1];
        b_neg_s     = op_signed_s & OperandB[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -OperandA;
        end else begin
            a_mag_s = OperandA;
        end
        if (b_neg_s) begin
            b_mag_s = -OperandB;
        end else begin
            b_mag_s = OperandB;
        end
    end

    // Retire BITS_PER_CYCLE multiply or divide steps on the magnitudes.
    always_comb begin
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        shift_s = {(WIDTH+1){1'b0}};
        sum_s   = {(WIDTH+1){1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_q) begin
                shift_s = {acc_d, wrk_d[WIDTH-1]};
                wrk_d   = {wrk_d[WIDTH-2:0], 1'b0};
                if (shift_s >= {1'b0, opb_q}) begin
                    acc_d    = shift_s[WIDTH-1:0] - opb_q;
                    wrk_d[0] = 1'b1;
                end else begin
                    acc_d = shift_s[WIDTH-1:0];
                end
            end else begin
                if (wrk_d[0]) begin
                    sum_s = {1'b0, acc_d} + {1'b0, opb_q};
                end else begin
                    sum_s = {1'b0, acc_d};
                end
                acc_d = sum_s[WIDTH:1];
                wrk_d = {sum_s[0], wrk_d[WIDTH-1:1]};
            end
        end
    end

    // Sign-correct the finished magnitudes into the values HI/LO receive.
    always_comb begin
        prod_mag_s = {acc_q, wrk_q};
        if (neg_a_q ^ neg_b_q) begin
            prod_s = -prod_mag_s;
        end else begin
            prod_s = prod_mag_s;
        end
        if (is_div_q) begin
            // Remainder follows the dividend; a zero divisor returns it raw.
            if (neg_a_q) begin
                hi_res_s = -acc_q;
            end else begin
                hi_res_s = acc_q;
            end
            if (dbz_pend_q) begin
                lo_res_s = {WIDTH{1'b1}};
            end else if (neg_a_q ^ neg_b_q) begin
                lo_res_s = -wrk_q;
            end else begin
                lo_res_s = wrk_q;
            end
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencing FSM: accept in IDLE, iterate in RUN, write HI/LO on COMMIT exit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {WIDTH{1'b0}};
            wrk_q      <= {WIDTH{1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    if (Start && op_iter_s) begin
                        is_div_q   <= (Op == OP_DIV) || (Op == OP_DIVU);
                        neg_a_q    <= a_neg_s;
                        neg_b_q    <= b_neg_s;
                        dbz_pend_q <= ((Op == OP_DIV) || (Op == OP_DIVU)) &&
                                      (OperandB == {WIDTH{1'b0}});
                        acc_q      <= {WIDTH{1'b0}};
                        wrk_q      <= a_mag_s;
                        opb_q      <= b_mag_s;
                        cnt_q      <= CNT_W'(N);
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end else if (Start && (Op == OP_MTHI)) begin
                        hi_q <= OperandA;
                    end else if (Start && (Op == OP_MTLO)) begin
                        lo_q <= OperandA;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    wrk_q <= wrk_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_q  <= 1'b1;
                        dbz_q   <= dbz_pend_q;
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    hi_q    <= hi_res_s;
                    lo_q    <= lo_res_s;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    // Fetch freezes only when something wants the unit while it is occupied.
    assign Stall     = busy_q & ((Start & op_live_s) | ReadHiLo);

endmodule
